// File: rtl/ram_bus_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module   : ram_bus_arbiter_if
// Brief    : Per-master command/ack bundle between a RAM client and the
//            two-master RAM bus arbiter.
// Revision : 1.0 - initial release
// ============================================================================
interface ram_bus_arbiter_if #(
  parameter int AW = 23,
  parameter int DW = 16
);
  logic          req;    // command request, held until ack
  logic          instr;  // 0 = READ, 1 = WRITE
  logic [AW-1:0] addr;   // word address
  logic [DW-1:0] wdata;  // write data (ignored on READ)
  logic          ack;    // one-cycle completion pulse
  logic [DW-1:0] rdata;  // read data, valid in the ack cycle

  // client side
  modport master (
    output req,
    output instr,
    output addr,
    output wdata,
    input  ack,
    input  rdata
  );

  // arbiter side
  modport slave (
    input  req,
    input  instr,
    input  addr,
    input  wdata,
    output ack,
    output rdata
  );
endinterface
`default_nettype wire

// File: rtl/ram_bus_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : ram_bus_arbiter
// Brief    : Round-robin arbiter giving two RAM clients (m0 = DNA initializer,
//            m1 = network evaluator) exclusive use of the single-command RAM
//            controller port. One command in flight, registered outputs,
//            per-master ack with read data, sticky timeout flag.
// Revision : 1.0 - initial release
// ============================================================================
module ram_bus_arbiter #(
  parameter int AW       = 23,
  parameter int DW       = 16,
  parameter int BUSY_TMO = 64,
  parameter int DONE_TMO = 4096
) (
  input  logic             clk,
  input  logic             rst,
  ram_bus_arbiter_if.slave m0,
  ram_bus_arbiter_if.slave m1,
  output logic             ram_instr_o,
  output logic             ram_latch_o,
  output logic [AW-1:0]    ram_addr_o,
  output logic [DW-1:0]    ram_wdata_o,
  input  logic [DW-1:0]    ram_rdata_i,
  input  logic             ram_ready_i,
  output logic             gnt_id_o,
  output logic             busy_o,
  output logic             err_timeout_o
);

  // One counter serves both wait phases, sized for the longer limit.
  localparam int TMO_MAX = (BUSY_TMO > DONE_TMO) ? BUSY_TMO : DONE_TMO;
  localparam int CW      = (TMO_MAX > 1) ? $clog2(TMO_MAX) : 1;
  localparam logic [CW-1:0] C_BUSY_LAST = CW'(BUSY_TMO - 1);
  localparam logic [CW-1:0] C_DONE_LAST = CW'(DONE_TMO - 1);

  localparam logic [2:0] S_IDLE      = 3'd0;
  localparam logic [2:0] S_LATCH     = 3'd1;
  localparam logic [2:0] S_WAIT_BUSY = 3'd2;
  localparam logic [2:0] S_WAIT_DONE = 3'd3;
  localparam logic [2:0] S_ACK       = 3'd4;

  logic [2:0]    state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          instr_q, instr_d;
  logic          latch_q, latch_d;
  logic [AW-1:0] addr_q, addr_d;
  logic [DW-1:0] wdata_q, wdata_d;
  logic          ack0_q, ack0_d;
  logic          ack1_q, ack1_d;
  logic [DW-1:0] rdata0_q, rdata0_d;
  logic [DW-1:0] rdata1_q, rdata1_d;
  logic          gnt_q, gnt_d;
  logic          busy_q, busy_d;
  logic          err_q, err_d;

  logic          win;      // master that would be granted this cycle
  logic [CW-1:0] cnt_inc;  // saturating increment of the wait counter

  // On a tie the master that did not own the last command wins.
  assign win     = (m0.req && m1.req) ? ~gnt_q : m1.req;
  assign cnt_inc = (cnt_q == {CW{1'b1}}) ? cnt_q : cnt_q + CW'(1);

  // Next-state and output logic of the command sequencer.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    instr_d  = instr_q;
    latch_d  = 1'b0;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    ack0_d   = 1'b0;
    ack1_d   = 1'b0;
    rdata0_d = rdata0_q;
    rdata1_d = rdata1_q;
    gnt_d    = gnt_q;
    busy_d   = busy_q;
    err_d    = err_q;

    case (state_q)
      S_IDLE: begin
        if (ram_ready_i && (m0.req || m1.req)) begin
          gnt_d   = win;
          instr_d = win ? m1.instr : m0.instr;
          addr_d  = win ? m1.addr  : m0.addr;
          wdata_d = win ? m1.wdata : m0.wdata;
          latch_d = 1'b1;
          busy_d  = 1'b1;
          state_d = S_LATCH;
        end
      end

      S_LATCH: begin
        cnt_d   = '0;
        state_d = S_WAIT_BUSY;
      end

      S_WAIT_BUSY: begin
        if (!ram_ready_i) begin
          cnt_d   = '0;
          state_d = S_WAIT_DONE;
        end else if (cnt_q == C_BUSY_LAST) begin
          err_d   = 1'b1;
          ack0_d  = ~gnt_q;
          ack1_d  = gnt_q;
          state_d = S_ACK;
        end else begin
          cnt_d = cnt_inc;
        end
      end

      S_WAIT_DONE: begin
        if (ram_ready_i) begin
          // Writes leave the owner's read-data register untouched.
          if (!instr_q) begin
            if (gnt_q) rdata1_d = ram_rdata_i;
            else       rdata0_d = ram_rdata_i;
          end
          ack0_d  = ~gnt_q;
          ack1_d  = gnt_q;
          state_d = S_ACK;
        end else if (cnt_q == C_DONE_LAST) begin
          err_d   = 1'b1;
          ack0_d  = ~gnt_q;
          ack1_d  = gnt_q;
          state_d = S_ACK;
        end else begin
          cnt_d = cnt_inc;
        end
      end

      S_ACK: begin
        busy_d  = 1'b0;
        state_d = S_IDLE;
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State registers; reset abandons any command in flight without an ack.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      instr_q  <= 1'b0;
      latch_q  <= 1'b0;
      addr_q   <= '0;
      wdata_q  <= '0;
      ack0_q   <= 1'b0;
      ack1_q   <= 1'b0;
      rdata0_q <= '0;
      rdata1_q <= '0;
      gnt_q    <= 1'b1;
      busy_q   <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      instr_q  <= instr_d;
      latch_q  <= latch_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      ack0_q   <= ack0_d;
      ack1_q   <= ack1_d;
      rdata0_q <= rdata0_d;
      rdata1_q <= rdata1_d;
      gnt_q    <= gnt_d;
      busy_q   <= busy_d;
      err_q    <= err_d;
    end
  end

  assign m0.ack        = ack0_q;
  assign m0.rdata      = rdata0_q;
  assign m1.ack        = ack1_q;
  assign m1.rdata      = rdata1_q;
  assign ram_instr_o   = instr_q;
  assign ram_latch_o   = latch_q;
  assign ram_addr_o    = addr_q;
  assign ram_wdata_o   = wdata_q;
  assign gnt_id_o      = gnt_q;
  assign busy_o        = busy_q;
  assign err_timeout_o = err_q;

endmodule
`default_nettype wire

// File: tb/tb_ram_bus_arbiter.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module   : tb_ram_bus_arbiter
// Brief    : Directed bench for ram_bus_arbiter with a transaction-level
//            expectation model, a simple RAM controller responder and
//            per-cycle output comparison.
// Revision : 1.0 - initial release
// ============================================================================
module tb_ram_bus_arbiter;
  localparam int AW       = 23;
  localparam int DW       = 16;
  localparam int BUSY_TMO = 16;
  localparam int DONE_TMO = 32;

  // d = cycles the controller waits before dropping ready, n = cycles it
  // holds ready low (0 = never drops), rv = data it returns.
  typedef struct packed {
    logic          instr;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
    logic [15:0]   d;
    logic [15:0]   n;
    logic [DW-1:0] rv;
  } cmd_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  ram_bus_arbiter_if #(.AW(AW), .DW(DW)) m0_if ();
  ram_bus_arbiter_if #(.AW(AW), .DW(DW)) m1_if ();

  logic          ram_instr, ram_latch, ram_ready, gnt_id, busy, err;
  logic [AW-1:0] ram_addr;
  logic [DW-1:0] ram_wdata;
  logic [DW-1:0] ram_rdata = '0;
  logic          ctl_ready = 1'b1;
  logic          hold_low  = 1'b0;
  assign ram_ready = ctl_ready & ~hold_low;

  ram_bus_arbiter #(.AW(AW), .DW(DW), .BUSY_TMO(BUSY_TMO), .DONE_TMO(DONE_TMO)) dut (
    .clk           (clk),
    .rst           (rst),
    .m0            (m0_if),
    .m1            (m1_if),
    .ram_instr_o   (ram_instr),
    .ram_latch_o   (ram_latch),
    .ram_addr_o    (ram_addr),
    .ram_wdata_o   (ram_wdata),
    .ram_rdata_i   (ram_rdata),
    .ram_ready_i   (ram_ready),
    .gnt_id_o      (gnt_id),
    .busy_o        (busy),
    .err_timeout_o (err)
  );

  int   total = 0;
  int   bad   = 0;
  int   cyc   = 0;
  cmd_t q0[$];
  cmd_t q1[$];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  function automatic cmd_t mk(input logic instr, input logic [AW-1:0] a, input logic [DW-1:0] wd,
                              input int d, input int n, input logic [DW-1:0] rv);
    cmd_t c;
    c.instr = instr; c.addr = a; c.wdata = wd; c.d = 16'(d); c.n = 16'(n); c.rv = rv;
    return c;
  endfunction

  // ---------------- expectation model (transaction level) ----------------
  logic          e_latch = 0, e_instr = 0, e_ack0 = 0, e_ack1 = 0, e_gnt = 1, e_busy = 0, e_err = 0;
  logic [AW-1:0] e_addr = '0;
  logic [DW-1:0] e_wdata = '0, e_rd0 = '0, e_rd1 = '0;
  logic          m_active = 0, m_w = 0, m_to = 0, m_rd = 0;
  logic [DW-1:0] m_rv = '0;
  int            m_a = 0;
  int            cur_d = 0, cur_n = 0;
  logic [DW-1:0] cur_rv = '0;

  // A command granted at edge g completes at a predicted edge; busy drops
  // one edge later and the next grant can come one edge after that.
  always @(posedge clk) begin
    cmd_t c;
    int   h, t;
    cyc     = cyc + 1;
    e_latch = 1'b0;
    e_ack0  = 1'b0;
    e_ack1  = 1'b0;
    if (rst) begin
      e_instr = 0; e_addr = '0; e_wdata = '0; e_rd0 = '0; e_rd1 = '0;
      e_gnt = 1; e_busy = 0; e_err = 0; m_active = 0;
    end else if (m_active) begin
      if (cyc == m_a) begin
        if (m_w) e_ack1 = 1'b1; else e_ack0 = 1'b1;
        if (m_to) e_err = 1'b1;
        else if (m_rd) begin
          if (m_w) e_rd1 = m_rv; else e_rd0 = m_rv;
        end
      end else if (cyc == m_a + 1) begin
        m_active = 0;
        e_busy   = 0;
      end
    end else if (ram_ready && (m0_if.req || m1_if.req)) begin
      m_w     = (m0_if.req && m1_if.req) ? !e_gnt : m1_if.req;
      c       = m_w ? q1[0] : q0[0];
      e_gnt   = m_w;
      e_latch = 1'b1;
      e_busy  = 1'b1;
      e_instr = c.instr;
      e_addr  = c.addr;
      e_wdata = c.wdata;
      cur_d   = int'(c.d);
      cur_n   = int'(c.n);
      cur_rv  = c.rv;
      m_rd    = !c.instr;
      m_rv    = c.rv;
      if (c.n == 0) begin
        m_a  = cyc + 1 + BUSY_TMO;
        m_to = 1'b1;
      end else begin
        h = cyc + 2 + int'(c.d) + int'(c.n);
        t = cyc + 2 + int'(c.d) + DONE_TMO;
        m_a  = (h <= t) ? h : t;
        m_to = (h > t);
      end
      m_active = 1;
    end
  end

  // ---------------- environment: controller responder and masters --------
  logic ctl_on = 0;
  int   ctl_t = 0, ctl_d = 0, ctl_n = 0;
  logic [DW-1:0] ctl_rv = '0;

  initial begin
    m0_if.req = 0; m0_if.instr = 0; m0_if.addr = '0; m0_if.wdata = '0;
    m1_if.req = 0; m1_if.instr = 0; m1_if.addr = '0; m1_if.wdata = '0;
  end

  always @(negedge clk) begin
    if (rst) begin
      ctl_ready = 1'b1;
      ctl_on    = 0;
    end else begin
      if (ctl_on) begin
        ctl_t++;
        if (ctl_n != 0 && ctl_t == ctl_d + 1) ctl_ready = 1'b0;
        if (ctl_n != 0 && ctl_t == ctl_d + 1 + ctl_n) begin
          ctl_ready = 1'b1;
          ram_rdata = ctl_rv;
          ctl_on    = 0;
        end
      end
      if (ram_latch) begin
        ctl_on = 1; ctl_t = 0; ctl_d = cur_d; ctl_n = cur_n; ctl_rv = cur_rv;
      end
    end
    if (m0_if.ack && q0.size() != 0) void'(q0.pop_front());
    if (m1_if.ack && q1.size() != 0) void'(q1.pop_front());
    m0_if.req = (q0.size() != 0);
    if (q0.size() != 0) begin
      m0_if.instr = q0[0].instr; m0_if.addr = q0[0].addr; m0_if.wdata = q0[0].wdata;
    end
    m1_if.req = (q1.size() != 0);
    if (q1.size() != 0) begin
      m1_if.instr = q1[0].instr; m1_if.addr = q1[0].addr; m1_if.wdata = q1[0].wdata;
    end
  end

  // ---------------- monitor ----------------
  int            n_latch = 0, n_ack0 = 0, n_ack1 = 0;
  int            last_latch_cyc = 0, last_ack_cyc = 0, err_cyc = 0;
  logic          err_was = 0;
  logic          gnt_hist[$];
  logic [AW-1:0] lat_addr = '0;
  logic [DW-1:0] lat_wdata = '0;
  logic          lat_instr = 0;

  always @(negedge clk) begin
    if (ram_latch === 1'b1) begin
      n_latch++;
      last_latch_cyc = cyc;
      gnt_hist.push_back(gnt_id);
      lat_addr = ram_addr; lat_wdata = ram_wdata; lat_instr = ram_instr;
    end
    if (m0_if.ack === 1'b1) begin n_ack0++; last_ack_cyc = cyc; end
    if (m1_if.ack === 1'b1) begin n_ack1++; last_ack_cyc = cyc; end
    if (err === 1'b1 && !err_was) err_cyc = cyc;
    err_was = (err === 1'b1);
  end

  // ---------------- per-cycle comparison against the model ----------------
  always @(negedge clk) begin
    if (cyc > 0) begin
      chk("ram_latch", 32'(ram_latch), 32'(e_latch));
      chk("ram_instr", 32'(ram_instr), 32'(e_instr));
      chk("ram_addr",  32'(ram_addr),  32'(e_addr));
      chk("ram_wdata", 32'(ram_wdata), 32'(e_wdata));
      chk("m0_ack",    32'(m0_if.ack), 32'(e_ack0));
      chk("m1_ack",    32'(m1_if.ack), 32'(e_ack1));
      chk("m0_rdata",  32'(m0_if.rdata), 32'(e_rd0));
      chk("m1_rdata",  32'(m1_if.rdata), 32'(e_rd1));
      chk("gnt_id",    32'(gnt_id), 32'(e_gnt));
      chk("busy",      32'(busy),   32'(e_busy));
      chk("err_timeout", 32'(err),  32'(e_err));
      chk("ack exclusive", 32'(m0_if.ack & m1_if.ack), 32'(0));
    end
  end

  // ---------------- directed stimulus ----------------
  task automatic step();
    @(negedge clk);
    #1;
  endtask

  task automatic wait_idle(input string nm, input int budget);
    int k = 0;
    while ((q0.size() != 0 || q1.size() != 0 || busy !== 1'b0) && k < budget) begin
      step();
      k++;
    end
    chk({nm, " completion within budget"}, 32'(k < budget), 32'(1));
    step();
  endtask

  task automatic wait_latch(input string nm, input int budget);
    int b = n_latch;
    int k = 0;
    while (n_latch == b && k < budget) begin
      step();
      k++;
    end
    chk({nm, " latch within budget"}, 32'(n_latch != b), 32'(1));
  endtask

  initial begin
    int b_l, b_a0, b_a1, b_a;
    repeat (3) step();
    chk("reset gnt_id", 32'(gnt_id), 32'(1));
    chk("reset busy", 32'(busy), 32'(0));
    chk("reset latch", 32'(ram_latch), 32'(0));
    rst = 1'b0;

    // 1: single m0 write, controller drops ready one cycle after latch for 5
    b_l = n_latch; b_a1 = n_ack1;
    q0.push_back(mk(1'b1, 23'h000010, 16'hBEEF, 1, 5, 16'h0000));
    wait_idle("t1", 100);
    chk("t1 latch count", 32'(n_latch - b_l), 32'(1));
    chk("t1 latched addr", 32'(lat_addr), 32'h10);
    chk("t1 latched wdata", 32'(lat_wdata), 32'hBEEF);
    chk("t1 latched instr", 32'(lat_instr), 32'(1));
    chk("t1 grant-to-ack edges", 32'(last_ack_cyc - last_latch_cyc), 32'(8));
    chk("t1 no m1 ack", 32'(n_ack1 - b_a1), 32'(0));

    // 2: both masters request together, four writes each; m0 owned the last
    // command so m1 wins the first tie and grants alternate from there
    b_l = n_latch; b_a0 = n_ack0; b_a1 = n_ack1;
    for (int i = 0; i < 4; i++) begin
      q0.push_back(mk(1'b1, AW'(23'h100 + i), DW'(16'hA000 + i), 0, 1, 16'h0000));
      q1.push_back(mk(1'b1, AW'(23'h200 + i), DW'(16'hB000 + i), 0, 2, 16'h0000));
    end
    wait_idle("t2", 300);
    for (int i = 0; i < 8; i++)
      chk("t2 grant order", 32'(gnt_hist[b_l + i]), 32'((i % 2 == 0) ? 1 : 0));
    chk("t2 m0 acks", 32'(n_ack0 - b_a0), 32'(4));
    chk("t2 m1 acks", 32'(n_ack1 - b_a1), 32'(4));

    // 3: m1 read at top address
    q1.push_back(mk(1'b0, 23'h7FFFFF, 16'h0000, 0, 2, 16'h1234));
    wait_idle("t3", 100);
    chk("t3 m1_rdata", 32'(m1_if.rdata), 32'h1234);
    chk("t3 m0_rdata unchanged", 32'(m0_if.rdata), 32'h0);

    // 4: ready held low at request time
    b_l = n_latch;
    hold_low = 1'b1;
    q0.push_back(mk(1'b0, 23'h000055, 16'h0000, 0, 1, 16'h0F0F));
    repeat (8) step();
    chk("t4 no latch while not ready", 32'(n_latch - b_l), 32'(0));
    hold_low = 1'b0;
    wait_idle("t4", 100);
    chk("t4 latch after ready", 32'(n_latch - b_l), 32'(1));
    chk("t4 m0_rdata", 32'(m0_if.rdata), 32'h0F0F);
    chk("t4 no error", 32'(err), 32'(0));

    // boundary: controller busy exactly DONE_TMO cycles still completes
    q1.push_back(mk(1'b0, 23'h000300, 16'h0000, 0, DONE_TMO, 16'h5A5A));
    wait_idle("done boundary", 200);
    chk("done boundary no error", 32'(err), 32'(0));
    chk("done boundary m1_rdata", 32'(m1_if.rdata), 32'h5A5A);

    // 5: controller never drops ready -> busy timeout
    b_a0 = n_ack0;
    q0.push_back(mk(1'b1, 23'h000400, 16'h1111, 0, 0, 16'h0000));
    wait_idle("t5", 200);
    chk("t5 err set", 32'(err), 32'(1));
    chk("t5 grant-to-err edges", 32'(err_cyc - last_latch_cyc), 32'(BUSY_TMO + 1));
    chk("t5 ack issued", 32'(n_ack0 - b_a0), 32'(1));

    // controller stuck low past DONE_TMO -> done timeout, rdata kept
    b_a1 = n_ack1;
    q1.push_back(mk(1'b0, 23'h000500, 16'h0000, 0, DONE_TMO + 5, 16'hDEAD));
    wait_idle("done timeout", 200);
    chk("done timeout err sticky", 32'(err), 32'(1));
    chk("done timeout ack issued", 32'(n_ack1 - b_a1), 32'(1));
    chk("done timeout m1_rdata kept", 32'(m1_if.rdata), 32'h5A5A);
    for (int k = 0; k < 50 && ram_ready !== 1'b1; k++) step();
    step();

    // 6: reset while waiting for the controller
    b_a = n_ack0 + n_ack1;
    q0.push_back(mk(1'b0, 23'h000600, 16'h0000, 0, 10, 16'h7777));
    wait_latch("t6", 50);
    repeat (4) step();
    rst = 1'b1;
    step();
    chk("t6 rst latch", 32'(ram_latch), 32'(0));
    chk("t6 rst addr", 32'(ram_addr), 32'(0));
    chk("t6 rst gnt_id", 32'(gnt_id), 32'(1));
    chk("t6 rst busy", 32'(busy), 32'(0));
    chk("t6 rst err", 32'(err), 32'(0));
    chk("t6 rst m1_rdata", 32'(m1_if.rdata), 32'(0));
    chk("t6 no ack for aborted", 32'(n_ack0 + n_ack1 - b_a), 32'(0));
    q1.push_back(mk(1'b1, 23'h000700, 16'h2222, 0, 1, 16'h0000));
    step();
    b_l = n_latch;
    rst = 1'b0;
    wait_latch("t6 regrant", 50);
    chk("t6 first grant after reset", 32'(gnt_hist[b_l]), 32'(0));
    wait_idle("t6", 200);
    chk("t6 acks after reissue", 32'(n_ack0 + n_ack1 - b_a), 32'(2));
    chk("t6 m0_rdata", 32'(m0_if.rdata), 32'h7777);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
`default_nettype wire
